// File: rtl/reg_file_dump_pkg.sv
// Shared definitions for the register-file dump engine: state encoding,
// default register count and the checksum helper.
package reg_file_dump_pkg;

    localparam int DUMP_NUM_REGS = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CAPTURE  = 3'd1;
    localparam logic [2:0] S_SEND_HI  = 3'd2;
    localparam logic [2:0] S_SEND_LO  = 3'd3;
    localparam logic [2:0] S_SEND_SUM = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // Byte that brings the running sum of all sent bytes to zero mod 256.
    function automatic logic [7:0] csum_byte(input logic [7:0] sum);
        return 8'd0 - sum;
    endfunction

endpackage

// File: rtl/reg_file_dump.sv
// Walks register addresses 0..NUM_REGS-1, snapshots each register and streams
// it high byte first over a valid/ready byte port, followed by a checksum byte.
module reg_file_dump
    import reg_file_dump_pkg::*;
#(
    parameter int NUM_REGS = DUMP_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [15:0]       Rd_Data,
    output logic [7:0]        Byte_Out,
    output logic              Byte_Valid,
    input  logic              Byte_Ready,
    output logic              Busy,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic [15:0]       shadow_q, shadow_d;
    logic              xfer;

    assign xfer = Byte_Valid && Byte_Ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sum_d    = sum_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (Start) begin
                    sum_d   = 8'd0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                shadow_d = Rd_Data;
                state_d  = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (xfer) begin
                    sum_d   = sum_q + shadow_q[15:8];
                    state_d = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (xfer) begin
                    sum_d = sum_q + shadow_q[7:0];
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_SEND_SUM;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_SEND_SUM: begin
                // Address is cleared here so it already reads 0 in the DONE cycle.
                if (xfer) begin
                    addr_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            sum_q    <= 8'd0;
            shadow_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sum_q    <= sum_d;
            shadow_q <= shadow_d;
        end
    end

    // Outputs depend only on registered state, never on Byte_Ready.
    always_comb begin
        Byte_Out = 8'd0;
        case (state_q)
            S_SEND_HI:  Byte_Out = shadow_q[15:8];
            S_SEND_LO:  Byte_Out = shadow_q[7:0];
            S_SEND_SUM: Byte_Out = csum_byte(sum_q);
            default:    Byte_Out = 8'd0;
        endcase
    end

    assign Byte_Valid = (state_q == S_SEND_HI) || (state_q == S_SEND_LO) ||
                        (state_q == S_SEND_SUM);
    assign Busy       = Byte_Valid || (state_q == S_CAPTURE);
    assign Done       = (state_q == S_DONE);
    assign Rd_Addr    = addr_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed and randomized dumps of a modelled 8x16 register file, checked
// against the byte stream, checksum, handshake and cycle timing expected.
module tb_reg_file_dump;

    logic        Clk = 1'b0;
    logic        Reset, Start, Byte_Ready;
    logic [2:0]  Rd_Addr;
    logic [15:0] Rd_Data;
    logic [7:0]  Byte_Out;
    logic        Byte_Valid, Busy, Done;

    logic [15:0] rf   [8];
    logic [15:0] expv [8];
    int total = 0;
    int bad   = 0;

    assign Rd_Data = rf[Rd_Addr];
    always #5 Clk = ~Clk;

    reg_file_dump dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Rd_Addr(Rd_Addr),
        .Rd_Data(Rd_Data), .Byte_Out(Byte_Out), .Byte_Valid(Byte_Valid),
        .Byte_Ready(Byte_Ready), .Busy(Busy), .Done(Done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, Byte_Valid, 1'b0);
        chk({tag, "_busy"},  Busy,       1'b0);
        chk({tag, "_done"},  Done,       1'b0);
        chk({tag, "_addr"},  Rd_Addr,    3'd0);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    // rmode: 0 ready always, 1 ready toggles, 2 ready random.
    task automatic run_dump(input int rmode, input bit spam, input int abort_cyc,
                            input bit wr_mid);
        logic [7:0] got [$];
        logic [7:0] expb [$];
        int cyc, ntx, stalls, s, ea;
        bit done_seen, wrote, pv, pr;
        logic [7:0] pb;

        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        cyc = 1; ntx = 0; stalls = 0; done_seen = 0; wrote = 0; pv = 0; pr = 0; pb = 0;
        while (!done_seen && cyc < 300) begin
            if (pv && !pr) begin
                chk("stall_valid", Byte_Valid, 1'b1);
                chk("stall_byte",  Byte_Out,   pb);
            end
            if (cyc == 1) chk("capture_valid", Byte_Valid, 1'b0);
            if (cyc == 2) chk("first_valid",   Byte_Valid, 1'b1);
            if (Done) begin
                done_seen = 1;
                chk("done_cycle", cyc, 26 + stalls);
                chk("done_nbytes", got.size(), 17);
                chk("done_busy", Busy, 1'b0);
                chk("done_addr", Rd_Addr, 3'd0);
                Start = spam;
            end else begin
                ea = (ntx / 2 > 7) ? 7 : ntx / 2;
                chk("busy", Busy, 1'b1);
                chk("rd_addr", Rd_Addr, ea);
                case (rmode)
                    0:       Byte_Ready = 1'b1;
                    1:       Byte_Ready = (cyc % 2 == 0);
                    default: Byte_Ready = 1'($urandom % 2);
                endcase
                if (wr_mid && !wrote && ntx == 2 && Byte_Valid) begin
                    rf[3] = 16'hBEEF;
                    rf[0] = 16'hFFFF;
                    wrote = 1;
                end
                if (Byte_Valid) begin
                    if (!Byte_Ready) stalls++;
                    else begin
                        got.push_back(Byte_Out);
                        ntx++;
                    end
                end
                Start = spam ? 1'($urandom % 2) : 1'b0;
            end
            pv = Byte_Valid; pr = Byte_Ready; pb = Byte_Out;
            if (cyc == abort_cyc) begin
                Reset = 1'b1;
                Start = 1'b0;
                @(posedge Clk); #1;
                Reset = 1'b0;
                chk_idle("abort");
                chk("abort_byte", Byte_Out, 8'h00);
                @(posedge Clk); #1;
                chk_idle("abort_after");
                return;
            end
            @(posedge Clk); #1;
            cyc++;
        end
        Start = 1'b0;
        if (!done_seen) chk("timeout", 1'b0, 1'b1);

        s = 0;
        for (int r = 0; r < 8; r++) begin
            expb.push_back(expv[r][15:8]);
            expb.push_back(expv[r][7:0]);
            s += expv[r][15:8] + expv[r][7:0];
        end
        expb.push_back(8'((256 - (s % 256)) % 256));
        for (int i = 0; i < 17; i++) begin
            if (i < got.size()) chk($sformatf("byte%0d", i), got[i], expb[i]);
            else chk($sformatf("byte%0d_missing", i), 1'b0, 1'b1);
        end
        s = 0;
        foreach (got[i]) s += got[i];
        chk("total_sum", s % 256, 0);

        for (int k = 0; k < 4; k++) begin
            chk_idle("post");
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) rf[r] = 16'h0000;
        Reset = 1'b1; Start = 1'b0; Byte_Ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk_idle("reset");
        chk("reset_byte", Byte_Out, 8'h00);
        Reset = 1'b0;
        @(posedge Clk); #1;

        expv = rf;
        run_dump(0, 0, 0, 0);

        rf[0] = 16'h0102;
        expv = rf;
        run_dump(0, 0, 0, 0);

        for (int r = 0; r < 8; r++) rf[r] = 16'(16'h1111 * (r + 1));
        expv = rf;
        run_dump(1, 0, 0, 0);

        expv = rf;
        expv[3] = 16'hBEEF;
        run_dump(0, 0, 0, 1);

        for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
        expv = rf;
        run_dump(2, 1, 0, 0);

        run_dump(0, 0, 10, 0);
        for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
        expv = rf;
        run_dump(0, 0, 0, 0);

        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
            expv = rf;
            run_dump(2, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
